ifu_line_fetcher: RTL



---
 rtl/ifu_line_fetcher_pkg.sv | 22 ++
 rtl/ifu_line_fetcher.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/ifu_line_fetcher_pkg.sv
// Shared frontend definitions: line geometry, reset fetch address and fetch FSM states.
package ifu_line_fetcher_pkg;

    localparam int unsigned LINE_BYTES    = 64;
    localparam int unsigned LINE_OFF_W    = 6;
    localparam int unsigned INST_PER_LINE = 16;
    localparam int unsigned LINE_BITS     = LINE_BYTES * 8;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitResp,
        StDeliver
    } fetch_state_e;

    function automatic logic [63:0] line_align(input logic [63:0] addr);
        return {addr[63:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/ifu_line_fetcher.sv
// Fetches 64-byte instruction lines from the arbiter and hands them to the instruction buffer,
// tracking refill requests and backend redirects.
module ifu_line_fetcher
    import ifu_line_fetcher_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fetch_inst,
    input  logic                 redirect_valid,
    input  logic [63:0]          redirect_target,
    output logic                 if2arb_req_valid,
    output logic [63:0]          if2arb_req_addr,
    input  logic                 arb2if_req_ready,
    input  logic                 arb2if_resp_valid,
    input  logic [LINE_BITS-1:0] arb2if_resp_data,
    output logic                 pc_index_ready,
    output logic [LINE_BITS-1:0] arb2ib_read_inst,
    output logic [63:0]          line_pc,
    output logic [3:0]           start_offset
);

    fetch_state_e         r_state, w_state_nxt;
    logic [63:0]          r_fetch_pc, w_fetch_pc_nxt;
    logic [63:0]          r_req_addr, w_req_addr_nxt;
    logic                 r_pending, w_pending_nxt;
    logic                 r_discard, w_discard_nxt;
    logic [3:0]           r_start_offset, w_start_offset_nxt;
    logic [LINE_BITS-1:0] r_line;
    logic [63:0]          r_line_pc;
    logic                 w_capture;
    logic [63:0]          w_next_line_pc;
    logic                 w_unused_target;

    assign w_next_line_pc  = r_fetch_pc + 64'(LINE_BYTES);
    assign w_unused_target = ^redirect_target[1:0];

    always_comb begin
        w_state_nxt        = r_state;
        w_fetch_pc_nxt     = r_fetch_pc;
        w_req_addr_nxt     = r_req_addr;
        w_pending_nxt      = r_pending;
        w_discard_nxt      = r_discard;
        w_start_offset_nxt = r_start_offset;
        w_capture          = 1'b0;

        case (r_state)
            StIdle: begin
                if (r_pending || fetch_inst) begin
                    w_state_nxt    = StReq;
                    w_pending_nxt  = 1'b0;
                    w_req_addr_nxt = r_fetch_pc;
                end
            end
            StReq: begin
                if (fetch_inst) w_pending_nxt = 1'b1;
                if (arb2if_req_ready) w_state_nxt = StWaitResp;
            end
            StWaitResp: begin
                if (fetch_inst) w_pending_nxt = 1'b1;
                if (arb2if_resp_valid) begin
                    if (r_discard) begin
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = StIdle;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = StDeliver;
                    end
                end
            end
            StDeliver: begin
                w_fetch_pc_nxt     = w_next_line_pc;
                w_start_offset_nxt = 4'd0;
                if (r_pending || fetch_inst) begin
                    w_state_nxt    = StReq;
                    w_pending_nxt  = 1'b0;
                    w_req_addr_nxt = w_next_line_pc;
                end else begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase

        // Redirect overrides everything; an in-flight request still finishes its handshake.
        if (redirect_valid) begin
            w_fetch_pc_nxt     = line_align(redirect_target);
            w_start_offset_nxt = redirect_target[LINE_OFF_W-1:2];
            w_pending_nxt      = 1'b1;
            w_capture          = 1'b0;
            case (r_state)
                StIdle:  w_state_nxt = StIdle;
                StReq:   w_discard_nxt = 1'b1;
                StWaitResp: begin
                    if (arb2if_resp_valid) begin
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = StIdle;
                    end else begin
                        w_discard_nxt = 1'b1;
                    end
                end
                StDeliver: w_state_nxt = StIdle;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= StIdle;
            r_fetch_pc     <= RESET_PC;
            r_req_addr     <= RESET_PC;
            r_pending      <= 1'b1;
            r_discard      <= 1'b0;
            r_start_offset <= 4'd0;
            r_line         <= '0;
            r_line_pc      <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_fetch_pc     <= w_fetch_pc_nxt;
            r_req_addr     <= w_req_addr_nxt;
            r_pending      <= w_pending_nxt;
            r_discard      <= w_discard_nxt;
            r_start_offset <= w_start_offset_nxt;
            if (w_capture) begin
                r_line    <= arb2if_resp_data;
                r_line_pc <= r_fetch_pc;
            end
        end
    end

    assign if2arb_req_valid = (r_state == StReq);
    assign if2arb_req_addr  = r_req_addr;
    assign pc_index_ready   = (r_state == StDeliver) && !redirect_valid;
    assign arb2ib_read_inst = r_line;
    assign line_pc          = r_line_pc;
    assign start_offset     = r_start_offset;

endmodule
